// File: rtl/prio_enc_seq.sv
// Sequential priority encoder: latches an N-bit request vector and emits the
// index of every set bit, one per output beat, in MSB-first or LSB-first order.
module prio_enc_seq #(
   parameter int unsigned N         = 16,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ei,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_vec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [$clog2(N)-1:0] out_idx,
   output logic                 out_last,
   output logic                 gs,
   output logic                 eo,
   output logic                 busy
);

   localparam int unsigned W = $clog2(N);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic           eo_q, eo_d;

   logic [W-1:0]   pick_idx;
   logic           pick_last;
   logic [N-1:0]   clr_mask;
   logic           accept;
   logic           beat;

   // Highest- or lowest-priority set bit; later loop iterations win.
   always_comb begin
      pick_idx = '0;
      if (MSB_FIRST) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (pending_q[i]) pick_idx = W'(i);
         end
      end else begin
         for (int unsigned i = N; i > 0; i--) begin
            if (pending_q[i-1]) pick_idx = W'(i - 1);
         end
      end
   end

   // Exactly one bit left means this beat drains the vector.
   assign pick_last = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);
   assign clr_mask  = N'(1) << pick_idx;
   assign accept    = in_valid && in_ready;
   assign beat      = (state_q == BUSY) && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         eo_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         eo_q      <= eo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      eo_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               pending_d = in_vec;
               if (in_vec != '0) state_d = BUSY;
               else              eo_d    = 1'b1;
            end
         end
         BUSY: begin
            if (beat) begin
               pending_d = pending_q & ~clr_mask;
               if (pick_last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // rst_n gates in_ready so nothing looks acceptable while reset is held.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_idx   = '0;
      out_last  = 1'b0;
      gs        = 1'b0;
      busy      = 1'b0;
      eo        = eo_q;
      unique case (state_q)
         IDLE: in_ready = ei && rst_n;
         BUSY: begin
            out_valid = 1'b1;
            out_idx   = pick_idx;
            out_last  = pick_last;
            gs        = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
